prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have parameter OCTA_FETCH, default 1, meaning 1 = octa reads yielding up to two instructions, 0 = tetra reads.
REQ-003 SHALL have ports, in order:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  permit new memory requests.
- redirect  in  1  one-cycle pulse: flush the queue and restart at redirect_ptr.
- redirect_ptr  in  64  new instruction pointer.
- head  out  fetch  oldest entry (loc, inst, interrupt, resuming=0).
- head_valid  out  1  head holds a valid entry.
- head_pop  in  1  consumer takes head this cycle.
- mem_address  out  64  physical byte address.
- mem_datasize  out  2  2 = tetra, 3 = octa.
- mem_read  out  1  read request, held until mem_done.
- mem_readdata  in  64  read data, big-endian.
- mem_done  in  1  one-cycle read completion.

Function
REQ-004 SHALL keep a fetch pointer fp, loaded by redirect_ptr on redirect and advanced by 4 per instruction pushed.
REQ-005 SHALL run an FSM with states IDLE, READ, DISCARD and HALT.
REQ-006 IDLE, with enable=1, fp[63]=1, fp[62:48]=0 and enough free slots (2 if OCTA_FETCH and fp[2]=0, else 1): SHALL drive mem_address={16'b0,fp[47:0]}, masked to 8-byte alignment in octa mode, set mem_read=1 and go to READ.
REQ-007 IDLE, with fp[63]=1 and fp[62:48]!=0 and one free slot: SHALL push {loc=fp, inst={SWYM,24'b0}, interrupt[PX_BIT]=1} and go to HALT.
REQ-008 IDLE, with fp[63]=0 and one free slot: SHALL push {loc=fp, inst=0, interrupt[F_BIT]=1}, set mem_address=fp and go to HALT.
REQ-009 READ on mem_done SHALL clear mem_read; in octa mode with fp[2]=0 it pushes readdata[63:32] at fp and readdata[31:0] at fp+4; otherwise it pushes the tetra selected by fp[2], with readdata[31:0] used when fp[2]=1 or in tetra mode; it then returns to IDLE.
REQ-010 HALT SHALL issue no requests until redirect.
REQ-011 Redirect SHALL empty the queue in the same cycle, load fp, and override any pop or push that cycle.
REQ-012 Redirect while mem_read=1 SHALL go to DISCARD, keeping mem_read and mem_address until mem_done; the data is dropped and the FSM then returns to IDLE.
REQ-013 Redirect in any other state SHALL go to IDLE.
REQ-014 head_valid SHALL equal count!=0; head_pop while empty SHALL be ignored.
REQ-015 Push and pop in the same cycle SHALL both take effect, with count changing by pushes-1.
REQ-016 Count SHALL never exceed DEPTH, because requests are gated by the free-slot check.
REQ-017 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-018 A request, once issued, SHALL not be withdrawn when enable deasserts; only new issues are blocked.
REQ-019 Issue-to-head latency SHALL be one cycle: the entry is visible the cycle after mem_done.
REQ-020 After pushing a fault entry, the unit SHALL issue no further entries (PX or F) until redirect.

Reset
REQ-021 On reset_n=0, the unit SHALL clear mem_read, head_valid, count, queue pointers, fp and mem_address, and enter IDLE.
REQ-022 Reset during READ SHALL abandon the request; a later mem_done while in IDLE SHALL be ignored.

Structure
REQ-023 The fetch struct, SWYM, PX_BIT and F_BIT SHALL come from the shared mmix_defs package, with no local redefinition.
REQ-024 The queue SHALL be a sub-module fetch_fifo (DEPTH, 2-push and 1-pop ports, flush), instantiated once.

Verification
REQ-025 Scenario: redirect to 0x8000_0000_0000_1000, octa mode, mem returns 0x11111111_22222222 -> two entries: loc 0x...1000 inst 0x11111111, then loc 0x...1004 inst 0x22222222.
REQ-026 Scenario: redirect to 0x8000_0000_0000_1004 -> one octa read at 0x...1000; single entry inst = readdata[31:0]; next read at 0x...1008.
REQ-027 Scenario: redirect to 0x8001_0000_0000_0000 -> one entry with SWYM and PX set, no mem_read; HALT until the next redirect.
REQ-028 Scenario: redirect to 0x0000_0000_0000_2000 -> F entry, mem_address=0x2000, no mem_read.
REQ-029 Scenario: DEPTH=4 with no pops -> exactly 4 entries, then mem_read stays 0; one pop frees a slot but issues nothing while fp[2]=0; two pops resume fetching.
REQ-030 Scenario: redirect in the cycle before mem_done -> stale data dropped, queue empty, next read at the new pointer.

Source files
------------

// File: rtl/mmix_defs_pkg.sv
// Shared MMIX definitions used by the instruction front end.
// Contents:
//   fetch_t      - one fetched instruction (location, word, interrupt bits, resume flag)
//   SWYM         - opcode of the no-op used to carry a protection fault
//   PX_BIT/F_BIT - interrupt bit positions for execute-protection and fetch faults
//   pf_state_t   - prefetch controller states
//   make_fetch   - builds a fetch_t with resuming cleared
package mmix_defs;

  localparam logic [7:0] SWYM   = 8'hFD;
  localparam int         PX_BIT = 37;
  localparam int         F_BIT  = 40;

  localparam logic [1:0] SIZE_TETRA = 2'd2;
  localparam logic [1:0] SIZE_OCTA  = 2'd3;

  typedef struct packed {
    logic [63:0] loc;
    logic [31:0] inst;
    logic [63:0] interrupt;
    logic        resuming;
  } fetch_t;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_READ    = 2'd1,
    PF_DISCARD = 2'd2,
    PF_HALT    = 2'd3
  } pf_state_t;

  function automatic fetch_t make_fetch(input logic [63:0] loc,
                                        input logic [31:0] inst,
                                        input logic [63:0] interrupt);
    fetch_t f;
    f.loc       = loc;
    f.inst      = inst;
    f.interrupt = interrupt;
    f.resuming  = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between the fetch controller and the consumer.
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   flush             - empties the queue; overrides push and pop that cycle
//   push0/data0       - first entry pushed this cycle
//   push1/data1       - second entry (only honoured together with push0)
//   pop               - consumer takes head; ignored while empty
//   head/head_valid   - oldest entry and its valid flag (combinational read)
//   count             - number of occupied entries, 0..DEPTH
module fetch_fifo
  import mmix_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push0,
  input  fetch_t                 data0,
  input  logic                   push1,
  input  fetch_t                 data1,
  input  logic                   pop,
  output fetch_t                 head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_p1;
  logic [1:0]    n_push;
  logic          do_pop;

  assign wr_ptr_p1 = wr_ptr_reg + PW'(1);
  assign n_push    = {1'b0, push0} + {1'b0, push0 & push1};
  assign do_pop    = pop && (count_reg != '0);

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push0)          mem[wr_ptr_reg] <= data0;
      if (push0 && push1) mem[wr_ptr_p1]  <= data1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(n_push);
      rd_ptr_reg <= rd_ptr_reg + PW'(do_pop);
      count_reg  <= count_reg + CW'(n_push) - CW'(do_pop);
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign head_valid = (count_reg != '0);
  assign count      = count_reg;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: walks the fetch pointer, issues tetra/octa memory
// reads, and queues fetched instructions (or a single fault entry) for the
// consumer.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   enable              - allows new memory requests to be issued
//   redirect/_ptr       - flush and restart fetching at redirect_ptr
//   head/head_valid     - oldest queued entry; head_pop consumes it
//   mem_address         - physical byte address of the current request
//   mem_datasize        - 2 = tetra, 3 = octa
//   mem_read            - request active, held until mem_done
//   mem_readdata        - big-endian read data
//   mem_done            - one-cycle completion strobe
module prefetch_unit
  import mmix_defs::*;
#(
  parameter int DEPTH      = 4,
  parameter int OCTA_FETCH = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        redirect,
  input  logic [63:0] redirect_ptr,
  output fetch_t      head,
  output logic        head_valid,
  input  logic        head_pop,
  output logic [63:0] mem_address,
  output logic [1:0]  mem_datasize,
  output logic        mem_read,
  input  logic [63:0] mem_readdata,
  input  logic        mem_done
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t     state_reg, state_next;
  logic [63:0]   fp_reg, fp_next;
  logic [63:0]   addr_reg, addr_next;
  logic          push0, push1;
  fetch_t        data0, data1;
  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] need_slots;
  logic          octa_pair;
  logic          fp_ok;

  // An octa read starting on an even tetra delivers two instructions and
  // therefore needs two free slots before it may be issued.
  assign octa_pair  = (OCTA_FETCH != 0) && !fp_reg[2];
  assign free_slots = CW'(DEPTH) - count;
  assign need_slots = octa_pair ? CW'(2) : CW'(1);
  assign fp_ok      = fp_reg[63] && (fp_reg[62:48] == '0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= PF_IDLE;
      fp_reg    <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      fp_reg    <= fp_next;
      addr_reg  <= addr_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    fp_next    = fp_reg;
    addr_next  = addr_reg;
    push0      = 1'b0;
    push1      = 1'b0;
    data0      = '0;
    data1      = '0;

    case (state_reg)
      PF_IDLE: begin
        if (fp_ok) begin
          if (enable && (free_slots >= need_slots)) begin
            addr_next  = (OCTA_FETCH != 0) ? {16'h0, fp_reg[47:3], 3'b000}
                                           : {16'h0, fp_reg[47:0]};
            state_next = PF_READ;
          end
        end else if (free_slots != '0) begin
          push0 = 1'b1;
          if (fp_reg[63]) begin
            // Unimplemented high address bits: deliver a protection fault
            data0 = make_fetch(fp_reg, {SWYM, 24'h0}, 64'd1 << PX_BIT);
          end else begin
            data0     = make_fetch(fp_reg, 32'h0, 64'd1 << F_BIT);
            addr_next = fp_reg;
          end
          state_next = PF_HALT;
        end
      end
      PF_READ: begin
        if (mem_done) begin
          push0      = 1'b1;
          state_next = PF_IDLE;
          if (octa_pair) begin
            push1   = 1'b1;
            data0   = make_fetch(fp_reg, mem_readdata[63:32], 64'h0);
            data1   = make_fetch(fp_reg + 64'd4, mem_readdata[31:0], 64'h0);
            fp_next = fp_reg + 64'd8;
          end else begin
            // Odd tetra of an octa, or a tetra read: low word holds it
            data0   = make_fetch(fp_reg, mem_readdata[31:0], 64'h0);
            fp_next = fp_reg + 64'd4;
          end
        end
      end
      PF_DISCARD: begin
        if (mem_done) state_next = PF_IDLE;
      end
      PF_HALT: begin
        state_next = PF_HALT;
      end
      default: begin
        state_next = PF_IDLE;
      end
    endcase

    // Redirect wins over everything above. A bus request in flight cannot be
    // cancelled, so it is drained in DISCARD unless it completes right now.
    if (redirect) begin
      push0     = 1'b0;
      push1     = 1'b0;
      fp_next   = redirect_ptr;
      addr_next = addr_reg;
      if (((state_reg == PF_READ) || (state_reg == PF_DISCARD)) && !mem_done)
        state_next = PF_DISCARD;
      else
        state_next = PF_IDLE;
    end
  end

  // Output logic
  always_comb begin
    mem_read     = (state_reg == PF_READ) || (state_reg == PF_DISCARD);
    mem_address  = addr_reg;
    mem_datasize = (OCTA_FETCH != 0) ? SIZE_OCTA : SIZE_TETRA;
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push0     (push0),
    .data0     (data0),
    .push1     (push1),
    .data1     (data1),
    .pop       (head_pop),
    .head      (head),
    .head_valid(head_valid),
    .count     (count)
  );

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level
// model (instruction queue, fetch pointer, one outstanding request).
module tb_prefetch_unit;
  import mmix_defs::*;

  localparam int DEPTH = 4;
  localparam int OCTA  = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        redirect;
  logic [63:0] redirect_ptr;
  fetch_t      head;
  logic        head_valid;
  logic        head_pop;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic [63:0] mem_readdata;
  logic        mem_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prefetch_unit #(.DEPTH(DEPTH), .OCTA_FETCH(OCTA)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .redirect    (redirect),
    .redirect_ptr(redirect_ptr),
    .head        (head),
    .head_valid  (head_valid),
    .head_pop    (head_pop),
    .mem_address (mem_address),
    .mem_datasize(mem_datasize),
    .mem_read    (mem_read),
    .mem_readdata(mem_readdata),
    .mem_done    (mem_done)
  );

  // ---------------- reference model ----------------
  logic [63:0] m_fp;
  logic [63:0] m_addr;
  bit          m_req;    // a bus request is outstanding
  bit          m_stale;  // its data belongs to a flushed stream
  bit          m_halt;   // a fault entry was delivered
  fetch_t      m_q[$];

  function automatic fetch_t mk(input logic [63:0] loc, input logic [31:0] inst,
                                input logic [63:0] intr);
    fetch_t f;
    f.loc = loc; f.inst = inst; f.interrupt = intr; f.resuming = 1'b0;
    return f;
  endfunction

  task automatic model_reset();
    m_fp = '0; m_addr = '0; m_req = 0; m_stale = 0; m_halt = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    int used;
    int need;
    used = m_q.size();
    if (redirect) begin
      m_q.delete();
      if (m_req && !mem_done) m_stale = 1;
      else begin m_req = 0; m_stale = 0; end
      m_halt = 0;
      m_fp   = redirect_ptr;
    end else begin
      if (head_pop && used > 0) void'(m_q.pop_front());
      if (m_req) begin
        if (mem_done) begin
          if (!m_stale) begin
            if (OCTA != 0 && !m_fp[2]) begin
              m_q.push_back(mk(m_fp, mem_readdata[63:32], 64'h0));
              m_q.push_back(mk(m_fp + 64'd4, mem_readdata[31:0], 64'h0));
              m_fp = m_fp + 64'd8;
            end else begin
              m_q.push_back(mk(m_fp, mem_readdata[31:0], 64'h0));
              m_fp = m_fp + 64'd4;
            end
          end
          m_req = 0; m_stale = 0;
        end
      end else if (!m_halt) begin
        if (m_fp[63] && m_fp[62:48] == 15'h0) begin
          need = (OCTA != 0 && !m_fp[2]) ? 2 : 1;
          if (enable && (DEPTH - used) >= need) begin
            m_req  = 1;
            m_addr = (OCTA != 0) ? {16'h0, m_fp[47:3], 3'b000} : {16'h0, m_fp[47:0]};
          end
        end else if (used < DEPTH) begin
          if (m_fp[63]) m_q.push_back(mk(m_fp, {SWYM, 24'h0}, 64'd1 << PX_BIT));
          else begin
            m_q.push_back(mk(m_fp, 32'h0, 64'd1 << F_BIT));
            m_addr = m_fp;
          end
          m_halt = 1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("mem_read", mem_read, m_req);
      chk("mem_address", mem_address, m_addr);
      chk("mem_datasize", mem_datasize, (OCTA != 0) ? 2'd3 : 2'd2);
      chk("head_valid", head_valid, m_q.size() != 0);
      if (head_valid && m_q.size() != 0) chk("head", head, m_q[0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_read(input string name);
    int n = 0;
    while (!mem_read && n < 50) begin tick(); n++; end
    chk(name, mem_read, 1'b1);
  endtask

  task automatic serve(input logic [63:0] d);
    wait_read("serve_wait");
    mem_readdata = d;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
  endtask

  task automatic do_redirect(input logic [63:0] p);
    redirect = 1'b1;
    redirect_ptr = p;
    tick();
    redirect = 1'b0;
  endtask

  task automatic quiesce();
    enable = 1'b0;
    if (mem_read) serve(64'h0);
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0]  r;
    logic [14:0] hi;
    reset_n = 1'b0; enable = 1'b0; redirect = 1'b0; redirect_ptr = '0;
    head_pop = 1'b0; mem_readdata = '0; mem_done = 1'b0;
    tick(); tick();
    $display("scenario reset");
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_head_valid", head_valid, 1'b0);
    chk("rst_mem_address", mem_address, 64'h0);
    reset_n = 1'b1;
    tick();

    $display("scenario octa pair");
    enable = 1'b1;
    do_redirect(64'h8000_0000_0000_1000);
    wait_read("s1_read");
    chk("s1_addr", mem_address, 64'h1000);
    serve(64'h11111111_22222222);
    chk("s1_valid", head_valid, 1'b1);
    chk("s1_loc0", head.loc, 64'h8000_0000_0000_1000);
    chk("s1_inst0", head.inst, 32'h11111111);
    chk("s1_model_inst0", m_q[0].inst, 32'h11111111);
    head_pop = 1'b1; tick(); head_pop = 1'b0;
    chk("s1_loc1", head.loc, 64'h8000_0000_0000_1004);
    chk("s1_inst1", head.inst, 32'h22222222);

    $display("scenario odd tetra");
    quiesce();
    enable = 1'b1;
    do_redirect(64'h8000_0000_0000_1004);
    wait_read("s2_read");
    chk("s2_addr", mem_address, 64'h1000);
    serve(64'hAAAAAAAA_BBBBBBBB);
    chk("s2_valid", head_valid, 1'b1);
    chk("s2_loc", head.loc, 64'h8000_0000_0000_1004);
    chk("s2_inst", head.inst, 32'hBBBBBBBB);
    wait_read("s2_next");
    chk("s2_next_addr", mem_address, 64'h1008);

    $display("scenario px fault");
    quiesce();
    enable = 1'b1;
    do_redirect(64'h8001_0000_0000_0000);
    tick();
    chk("s3_valid", head_valid, 1'b1);
    chk("s3_inst", head.inst, 32'hFD000000);
    chk("s3_px", head.interrupt[PX_BIT], 1'b1);
    chk("s3_model_px", m_q[0].interrupt, 64'd1 << 37);
    for (int i = 0; i < 4; i++) begin
      chk("s3_no_read", mem_read, 1'b0);
      tick();
    end
    head_pop = 1'b1; tick(); head_pop = 1'b0; tick();
    chk("s3_halt_empty", head_valid, 1'b0);

    $display("scenario f fault");
    do_redirect(64'h0000_0000_0000_2000);
    tick();
    chk("s4_valid", head_valid, 1'b1);
    chk("s4_loc", head.loc, 64'h2000);
    chk("s4_inst", head.inst, 32'h0);
    chk("s4_f", head.interrupt[F_BIT], 1'b1);
    chk("s4_addr", mem_address, 64'h2000);
    chk("s4_no_read", mem_read, 1'b0);

    $display("scenario full queue");
    do_redirect(64'h8000_0000_0000_3000);
    serve(64'h01010101_02020202);
    serve(64'h03030303_04040404);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s5_full_no_read", mem_read, 1'b0);
    end
    head_pop = 1'b1; tick(); head_pop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5_one_free_no_read", mem_read, 1'b0);
    end
    head_pop = 1'b1; tick(); head_pop = 1'b0;
    wait_read("s5_resume");
    chk("s5_addr", mem_address, 64'h3010);

    $display("scenario redirect before done");
    do_redirect(64'h8000_0000_0000_4000);
    mem_readdata = 64'hDEADBEEF_CAFEF00D;
    mem_done = 1'b1; tick(); mem_done = 1'b0;
    chk("s6_empty", head_valid, 1'b0);
    wait_read("s6_read");
    chk("s6_addr", mem_address, 64'h4000);
    chk("s6_still_empty", head_valid, 1'b0);

    $display("scenario reset during read");
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("s7_read", mem_read, 1'b0);
    chk("s7_valid", head_valid, 1'b0);
    chk("s7_addr", mem_address, 64'h0);
    mem_done = 1'b1; mem_readdata = 64'h12345678_9ABCDEF0; tick(); mem_done = 1'b0;
    chk("s7_f_entry", head.interrupt[F_BIT], 1'b1);
    chk("s7_f_loc", head.loc, 64'h0);
    chk("s7_no_read", mem_read, 1'b0);

    $display("scenario random traffic");
    for (int it = 0; it < 3000; it++) begin
      tick();
      reset_n  = ($urandom_range(0, 499) != 0);
      enable   = ($urandom_range(0, 3) != 0);
      head_pop = $urandom_range(0, 1);
      redirect = ($urandom_range(0, 39) == 0);
      r  = 10'($urandom);
      hi = 15'($urandom_range(1, 32767));
      case ($urandom_range(0, 5))
        4:       redirect_ptr = {1'b1, hi, 36'h0, r, 2'b00};
        5:       redirect_ptr = {1'b0, 51'h0, r, 2'b00};
        default: redirect_ptr = {16'h8000, 36'h0, r, 2'b00};
      endcase
      if (mem_done) mem_done = 1'b0;
      else if (mem_read && $urandom_range(0, 2) == 0) mem_done = 1'b1;
      else if (!mem_read && $urandom_range(0, 19) == 0) mem_done = 1'b1;
      mem_readdata = {$urandom, $urandom};
    end
    reset_n = 1'b1; redirect = 1'b0; mem_done = 1'b0; head_pop = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
